// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared constants for the multi-cycle arithmetic unit
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Step counter width; a counter of $clog2(W) bits reaches W-1 exactly.
  function automatic int cnt_bits(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/div_control.sv
// rtl/div_control.sv - IDLE/CALC/DONE sequencer and step counter for cyc_div
module div_control
  import arith_pkg::*;
#(
  parameter int W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic load_out,
  output logic calc,
  output logic valid
);

  localparam int CW = cnt_bits(W);

  div_state_e    state;
  div_state_e    state_nxt;
  logic [CW-1:0] cnt;
  logic          last_step;

  assign last_step = (cnt == CW'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (load)
        cnt <= '0;
      else if (state == ST_CALC)
        cnt <= cnt + 1'b1;
    end
  end

  // A load wins over everything, including an in-flight division.
  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = ST_CALC;
    end else begin
      case (state)
        ST_CALC: if (last_step) state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_DONE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    load_out = load;
    calc     = (state == ST_CALC) && !load;
    valid    = (state == ST_DONE);
  end

endmodule

// File: rtl/prop_adder.sv
// rtl/prop_adder.sv - ripple carry adder built from propagate/generate terms
module prop_adder #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0]   carry;
  logic [N-1:0] p;
  logic [N-1:0] g;

  assign carry[0] = cin;
  assign p        = a ^ b;
  assign g        = a & b;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign sum[i]     = p[i] ^ carry[i];
    assign carry[i+1] = g[i] | (p[i] & carry[i]);
  end

  assign cout = carry[N];

endmodule

// File: rtl/cyc_div.sv
// rtl/cyc_div.sv - W-cycle unsigned restoring divider, one shift-subtract per clock
module cyc_div
  import arith_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] q,
  output logic [W-1:0] r,
  output logic         valid,
  output logic         div_by_zero
);

  logic         load_out;
  logic         calc;
  logic [W-1:0] q_reg;
  logic [W-1:0] r_reg;
  logic [W-1:0] dvs_reg;
  logic         dz_reg;
  logic [W:0]   t;
  logic [W:0]   diff;
  logic         no_borrow;
  logic         unused_diff_msb;

  div_control #(.W(W)) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_out (load_out),
    .calc     (calc),
    .valid    (valid)
  );

  assign t = {r_reg, q_reg[W-1]};

  // Subtract by adding the inverted divisor plus one; carry-out means t >= divisor.
  prop_adder #(.N(W + 1)) u_sub (
    .a    (t),
    .b    (~{1'b0, dvs_reg}),
    .cin  (1'b1),
    .sum  (diff),
    .cout (no_borrow)
  );

  assign unused_diff_msb = diff[W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg   <= '0;
      r_reg   <= '0;
      dvs_reg <= '0;
      dz_reg  <= 1'b0;
    end else if (load_out) begin
      q_reg   <= a;
      r_reg   <= '0;
      dvs_reg <= b;
      dz_reg  <= (b == '0);
    end else if (calc) begin
      q_reg <= {q_reg[W-2:0], no_borrow};
      r_reg <= no_borrow ? diff[W-1:0] : t[W-1:0];
    end
  end

  assign q           = q_reg;
  assign r           = r_reg;
  assign div_by_zero = dz_reg;

endmodule

// File: tb/tb_cyc_div.sv
// tb/tb_cyc_div.sv - directed and randomized checks of cyc_div against an arithmetic model
module tb_cyc_div;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       load4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic [3:0] q4;
  logic [3:0] r4;
  logic       v4;
  logic       dz4;

  logic       load8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic [7:0] q8;
  logic [7:0] r8;
  logic       v8;
  logic       dz8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cyc_div #(.W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .load(load4), .a(a4), .b(b4),
    .q(q4), .r(r4), .valid(v4), .div_by_zero(dz4)
  );

  cyc_div #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .load(load8), .a(a8), .b(b8),
    .q(q8), .r(r8), .valid(v8), .div_by_zero(dz8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Quotient/remainder as defined by restoring division; b==0 gives all ones and a.
  function automatic int model_q(input int a, input int b, input int w);
    return (b == 0) ? ((1 << w) - 1) : a / b;
  endfunction

  function automatic int model_r(input int a, input int b);
    return (b == 0) ? a : a % b;
  endfunction

  task automatic run4(input string tag, input int a, input int b);
    int lat;
    load4 = 1'b1; a4 = 4'(a); b4 = 4'(b);
    step();
    load4 = 1'b0;
    lat = 0;
    while (!v4 && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_q"}, q4, model_q(a, b, 4));
    chk({tag, "_r"}, r4, model_r(a, b));
    chk({tag, "_dz"}, dz4, (b == 0) ? 1 : 0);
  endtask

  task automatic run8(input int a, input int b);
    int lat;
    load8 = 1'b1; a8 = 8'(a); b8 = 8'(b);
    step();
    load8 = 1'b0;
    lat = 0;
    while (!v8 && lat < 30) begin
      step();
      lat++;
    end
    chk("w8_lat", lat, 8);
    chk("w8_q", q8, model_q(a, b, 8));
    chk("w8_r", r8, model_r(a, b));
    chk("w8_dz", dz8, (b == 0) ? 1 : 0);
  endtask

  initial begin
    int lat;

    #2;
    chk("rst_q", q4, 0);
    chk("rst_r", r4, 0);
    chk("rst_valid", v4, 0);
    chk("rst_dz", dz4, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("idle_valid", v4, 0);

    run4("d13_3", 13, 3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_valid", v4, 1);
      chk("hold_q", q4, 4);
      chk("hold_r", r4, 1);
    end

    run4("d15_1", 15, 1);
    run4("b2b_2_9", 2, 9);
    run4("dz7_0", 7, 0);

    // Reload two steps into a division; only the second result may appear.
    load4 = 1'b1; a4 = 4'd12; b4 = 4'd5;
    step();
    load4 = 1'b0;
    step();
    step();
    chk("abort_valid", v4, 0);
    run4("reload9_2", 9, 2);

    // Asynchronous reset between edges.
    load4 = 1'b1; a4 = 4'd13; b4 = 4'd2;
    step();
    load4 = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_q", q4, 0);
    chk("async_r", r4, 0);
    chk("async_valid", v4, 0);
    chk("async_dz", dz4, 0);
    step();
    #3;
    rst_n = 1'b1;
    step();
    run4("post_rst10_4", 10, 4);

    // Continuous load never lets a result through.
    load4 = 1'b1; a4 = 4'd9; b4 = 4'd3;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("held_load_valid", v4, 0);
    end
    load4 = 1'b0;
    lat = 0;
    while (!v4 && lat < 20) begin
      step();
      lat++;
    end
    chk("held_load_lat", lat, 4);
    chk("held_load_q", q4, 3);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run4("exh", a, b);

    for (int i = 0; i < 200; i++)
      run8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    run8(255, 0);
    run8(255, 255);
    run8(0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
